// File: rtl/uart_pkg.sv
// Shared encodings for the UART channel executor: instruction set, TELL selectors,
// FSM state types and the divisor floor.
package uart_pkg;

    typedef enum logic [2:0] {
        INSTR_NOP     = 3'b000,
        INSTR_TELL    = 3'b001,
        INSTR_READ    = 3'b010,
        INSTR_WRITE   = 3'b011,
        INSTR_BAUDSET = 3'b100,
        INSTR_DBG1    = 3'b101,
        INSTR_DBG2    = 3'b110
    } uart_instr_t;

    localparam logic [7:0] TELL_COUNT    = 8'h00;
    localparam logic [7:0] TELL_STATUS   = 8'h01;
    localparam logic [7:0] TELL_OVERRUN  = 8'h02;
    localparam logic [7:0] TELL_FRAMING  = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT_TX,
        ST_WAIT_RX
    } cmd_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int UART_MIN_DIVISOR = 4;

    function automatic logic [15:0] clamp_divisor(input logic [15:0] value,
                                                  input logic [15:0] floor_val);
        return (value < floor_val) ? floor_val : value;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous RX byte FIFO; a pop in the same cycle lets a push land even when full.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_channel_exec.sv
// Executes decoded UART commands on one physical channel: 8N1 TX/RX, RX FIFO, baud divisor.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | ready for a command; the accept edge performs it if it can
// ST_EXEC    | one cycle; result_valid shown here, or heading to a wait
// ST_WAIT_TX | WRITE waits for TX free, BAUDSET waits for TX and RX idle
// ST_WAIT_RX | READ waits for a byte in the FIFO
module uart_channel_exec
    import uart_pkg::*;
#(
    parameter logic CHANNEL_ID      = 1'b0,
    parameter int   DEFAULT_DIVISOR = 434,
    parameter int   MIN_DIVISOR     = UART_MIN_DIVISOR,
    parameter int   RX_DEPTH        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        UART_channel,
    input  logic [2:0]  UART_instr,
    input  logic [7:0]  UART_code_value,
    input  logic [31:0] UART_write_value,
    output logic        result_valid,
    output logic [7:0]  result_reg,
    output logic [31:0] result_data,
    output logic        busy,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int CW = $clog2(RX_DEPTH) + 1;

    cmd_state_t  state;
    uart_instr_t cmd_instr;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_value;
    logic        pending;

    logic [15:0] divisor;
    logic [7:0]  overrun_cnt;
    logic [7:0]  framing_cnt;
    logic [15:0] tx_byte_cnt;
    logic [15:0] rx_byte_cnt;

    tx_state_t   tx_state;
    logic [15:0] tx_timer;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_data;

    rx_state_t   rx_state;
    logic [15:0] rx_timer;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_data;
    logic        rx_s1, rx_s2, rx_prev;

    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;

    uart_instr_t act_instr;
    logic [7:0]  act_code;
    logic [15:0] act_value;
    logic        accept, can_do, do_act, has_result;
    logic        tx_can_load, tx_load, baud_load, fifo_pop;
    logic        rx_stop_sample, rx_push, rx_frame_err;
    logic [31:0] res_data;
    logic        unused_write_hi;

    assign unused_write_hi = ^UART_write_value[31:16];

    assign accept         = cmd_valid & cmd_ready & (UART_channel == CHANNEL_ID);
    // Loading on the last stop-bit cycle chains frames with no idle gap.
    assign tx_can_load    = (tx_state == TX_IDLE) | ((tx_state == TX_STOP) & (tx_timer == 16'd0));
    assign rx_stop_sample = (rx_state == RX_STOP) & (rx_timer == 16'd0);
    assign rx_push        = rx_stop_sample & rx_s2;
    assign rx_frame_err   = rx_stop_sample & ~rx_s2;

    always_comb begin
        act_instr = cmd_instr;
        act_code  = cmd_code;
        act_value = cmd_value;
        if (state == ST_IDLE) begin
            act_instr = uart_instr_t'(UART_instr);
            act_code  = UART_code_value;
            act_value = UART_write_value[15:0];
        end

        case (act_instr)
            INSTR_READ:    can_do = ~fifo_empty;
            INSTR_WRITE:   can_do = tx_can_load;
            INSTR_BAUDSET: can_do = (tx_state == TX_IDLE) & (rx_state == RX_IDLE);
            default:       can_do = 1'b1;
        endcase

        do_act = can_do & (accept | (state == ST_WAIT_TX) | (state == ST_WAIT_RX));

        has_result = 1'b0;
        res_data   = 32'd0;
        case (act_instr)
            INSTR_TELL: begin
                has_result = 1'b1;
                case (act_code)
                    TELL_COUNT:   res_data = 32'(fifo_count);
                    TELL_STATUS:  res_data = {29'd0, tx_state != TX_IDLE, fifo_full, fifo_empty};
                    TELL_OVERRUN: res_data = {24'd0, overrun_cnt};
                    TELL_FRAMING: res_data = {24'd0, framing_cnt};
                    default:      res_data = 32'd0;
                endcase
            end
            INSTR_READ: begin
                has_result = 1'b1;
                res_data   = {24'd0, fifo_data};
            end
            INSTR_DBG1: begin
                has_result = 1'b1;
                res_data   = {16'd0, divisor};
            end
            INSTR_DBG2: begin
                has_result = 1'b1;
                res_data   = {tx_byte_cnt, rx_byte_cnt};
            end
            default: ;
        endcase
    end

    assign fifo_pop  = do_act & (act_instr == INSTR_READ);
    assign tx_load   = do_act & (act_instr == INSTR_WRITE);
    assign baud_load = do_act & (act_instr == INSTR_BAUDSET);

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_reg   <= 8'd0;
            result_data  <= 32'd0;
            pending      <= 1'b0;
            cmd_instr    <= INSTR_NOP;
            cmd_code     <= 8'd0;
            cmd_value    <= 16'd0;
        end else begin
            result_valid <= 1'b0;
            if (do_act & has_result) begin
                result_valid <= 1'b1;
                result_reg   <= act_code;
                result_data  <= res_data;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_EXEC;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        pending   <= ~can_do;
                        cmd_instr <= act_instr;
                        cmd_code  <= act_code;
                        cmd_value <= act_value;
                    end
                end
                ST_EXEC: begin
                    if (pending) begin
                        state <= (cmd_instr == INSTR_READ) ? ST_WAIT_RX : ST_WAIT_TX;
                    end else begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                ST_WAIT_TX, ST_WAIT_RX: begin
                    if (can_do) begin
                        state   <= ST_EXEC;
                        pending <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor     <= 16'(DEFAULT_DIVISOR);
            overrun_cnt <= 8'd0;
            framing_cnt <= 8'd0;
            tx_byte_cnt <= 16'd0;
            rx_byte_cnt <= 16'd0;
        end else begin
            if (baud_load) divisor <= clamp_divisor(act_value, 16'(MIN_DIVISOR));
            if (tx_load)   tx_byte_cnt <= tx_byte_cnt + 16'd1;
            if (rx_push)   rx_byte_cnt <= rx_byte_cnt + 16'd1;
            if (rx_push & fifo_full & ~fifo_pop & (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;
            if (rx_frame_err & (framing_cnt != 8'hFF))
                framing_cnt <= framing_cnt + 8'd1;
        end
    end

    // TX serializer: each bit held for divisor cycles by a down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            uart_tx  <= 1'b1;
            tx_timer <= 16'd0;
            tx_bit   <= 3'd0;
            tx_data  <= 8'd0;
        end else begin
            if (tx_timer != 16'd0) tx_timer <= tx_timer - 16'd1;
            case (tx_state)
                TX_IDLE, TX_STOP: begin
                    if (tx_load) begin
                        tx_state <= TX_START;
                        uart_tx  <= 1'b0;
                        tx_data  <= act_value[7:0];
                        tx_timer <= divisor - 16'd1;
                    end else if (tx_state == TX_STOP && tx_timer == 16'd0) begin
                        tx_state <= TX_IDLE;
                    end
                end
                TX_START: begin
                    if (tx_timer == 16'd0) begin
                        tx_state <= TX_DATA;
                        uart_tx  <= tx_data[0];
                        tx_bit   <= 3'd0;
                        tx_timer <= divisor - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_timer == 16'd0) begin
                        tx_timer <= divisor - 16'd1;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_bit  <= tx_bit + 3'd1;
                            uart_tx <= tx_data[tx_bit + 3'd1];
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX deserializer: samples mid-bit, starting half a bit after the falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_timer <= 16'd0;
            rx_bit   <= 3'd0;
            rx_data  <= 8'd0;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (rx_timer != 16'd0) rx_timer <= rx_timer - 16'd1;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev & ~rx_s2) begin
                        rx_state <= RX_START;
                        rx_timer <= (divisor >> 1) - 16'd1;
                    end
                end
                RX_START: begin
                    if (rx_timer == 16'd0) begin
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_bit   <= 3'd0;
                            rx_timer <= divisor - 16'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_timer == 16'd0) begin
                        rx_data[rx_bit] <= rx_s2;
                        rx_timer        <= divisor - 16'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_timer == 16'd0) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_channel_exec.sv
// Directed bench for uart_channel_exec: queue-based model of results, RX FIFO and TX frames.
module tb_uart_channel_exec;

    localparam logic [2:0] I_NOP   = 3'b000;
    localparam logic [2:0] I_TELL  = 3'b001;
    localparam logic [2:0] I_READ  = 3'b010;
    localparam logic [2:0] I_WRITE = 3'b011;
    localparam logic [2:0] I_BAUD  = 3'b100;
    localparam logic [2:0] I_DBG1  = 3'b101;
    localparam logic [2:0] I_DBG2  = 3'b110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        UART_channel = 1'b0;
    logic [2:0]  UART_instr = 3'b000;
    logic [7:0]  UART_code_value = 8'h00;
    logic [31:0] UART_write_value = 32'h0;
    logic        result_valid;
    logic [7:0]  result_reg;
    logic [31:0] result_data;
    logic        busy;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    uart_channel_exec #(
        .CHANNEL_ID      (1'b0),
        .DEFAULT_DIVISOR (434),
        .MIN_DIVISOR     (4),
        .RX_DEPTH        (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .UART_channel     (UART_channel),
        .UART_instr       (UART_instr),
        .UART_code_value  (UART_code_value),
        .UART_write_value (UART_write_value),
        .result_valid     (result_valid),
        .result_reg       (result_reg),
        .result_data      (result_data),
        .busy             (busy),
        .uart_tx          (uart_tx),
        .uart_rx          (uart_rx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { logic [7:0] r; logic [31:0] d; int at; } exp_t;
    typedef struct { logic [7:0] b; int div; } txexp_t;

    exp_t   exp_q[$];
    txexp_t tx_q[$];
    int     start_cyc[$];

    // Specification-level model state
    logic [7:0] m_fifo[$];
    int m_div = 434;
    int m_ovr = 0, m_frm = 0, m_txc = 0, m_rxc = 0;
    int last_drive_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    function automatic int clamp_div(input logic [31:0] v);
        int x;
        x = int'(v[15:0]);
        return (x < 4) ? 4 : x;
    endfunction

    task automatic send(input logic [2:0] ins, input logic [7:0] code, input logic [31:0] val,
                        input logic ch, input bit res, input bit lat1, input logic [31:0] exp_data);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
            return;
        end
        if (res) begin
            e.r = code; e.d = exp_data; e.at = lat1 ? cyc + 1 : -1;
            exp_q.push_back(e);
        end
        last_drive_cyc   = cyc;
        cmd_valid        = 1'b1;
        UART_instr       = ins;
        UART_code_value  = code;
        UART_write_value = val;
        UART_channel     = ch;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic tell(input logic [7:0] code, input logic [31:0] req);
        send(I_TELL, code, 32'h0, 1'b0, 1'b1, 1'b1, req);
    endtask

    task automatic write_byte(input logic [7:0] b);
        txexp_t t;
        t.b = b; t.div = m_div;
        tx_q.push_back(t);
        m_txc++;
        send(I_WRITE, 8'h00, {24'd0, b}, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (m_div) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (2 * m_div) @(negedge clk);
        if (stop_bit) begin
            m_rxc++;
            if (m_fifo.size() < 8) m_fifo.push_back(b);
            else if (m_ovr < 255) m_ovr++;
        end else if (m_frm < 255) begin
            m_frm++;
        end
    endtask

    logic mon_busy = 1'b0;

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while ((tx_q.size() != 0 || mon_busy || uart_tx !== 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("tx_idle_timeout", {31'd0, uart_tx}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    exp_t chk_e;
    always @(negedge clk) begin
        if (!rst && result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: reg 0x%02h data 0x%08h, none required", result_reg, result_data);
            end else begin
                chk_e = exp_q.pop_front();
                check("result_reg", {24'd0, result_reg}, {24'd0, chk_e.r});
                check("result_data", result_data, chk_e.d);
                if (chk_e.at >= 0) check("result_latency_cycle", cyc, chk_e.at);
            end
        end
    end

    logic   tx_prev = 1'b1;
    txexp_t mon_t;
    logic [9:0] mon_bits;
    int     mon_bad;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx_prev === 1'b1 && uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                start_cyc.push_back(cyc);
                if (tx_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tx_unexpected_frame: start bit at cycle %0d, no WRITE pending", cyc);
                    mon_t.b = 8'h00; mon_t.div = m_div;
                end else begin
                    mon_t = tx_q.pop_front();
                end
                mon_bits = {1'b1, mon_t.b, 1'b0};
                mon_bad = 0;
                for (int i = 0; i < 10; i++) begin
                    for (int j = 0; j < mon_t.div; j++) begin
                        if (i != 0 || j != 0) @(negedge clk);
                        if (uart_tx !== mon_bits[i]) mon_bad++;
                    end
                end
                check("tx_frame_bad_cycles", mon_bad, 0);
                mon_busy = 1'b0;
            end
            tx_prev = uart_tx;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_cmd_ready",    {31'd0, cmd_ready},    32'd1);
        check("reset_result_valid", {31'd0, result_valid}, 32'd0);
        check("reset_result_reg",   {24'd0, result_reg},   32'd0);
        check("reset_result_data",  result_data,           32'd0);
        check("reset_busy",         {31'd0, busy},         32'd0);
        check("reset_uart_tx",      {31'd0, uart_tx},      32'd1);
        rst = 1'b0;

        send(I_DBG1, 8'h11, 32'h0, 1'b0, 1'b1, 1'b1, 32'd434);
        send(I_NOP, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        send(I_BAUD, 8'h00, 32'd2, 1'b0, 1'b0, 1'b0, 32'h0);
        m_div = clamp_div(32'd2);
        send(I_DBG1, 8'h12, 32'h0, 1'b0, 1'b1, 1'b1, 32'd4);

        // Single frame 0x55 at divisor 4
        start_cyc.delete();
        write_byte(8'h55);
        wait_tx_idle();
        check("write_start_latency", start_cyc.size() > 0 ? start_cyc[0] : -1, last_drive_cyc + 1);
        send(I_DBG2, 8'h13, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0001_0000);

        // Back-to-back writes: second waits in WAIT_TX and chains with no gap
        start_cyc.delete();
        write_byte(8'hA5);
        write_byte(8'h3C);
        repeat (3) @(negedge clk);
        check("b2b_busy_waiting", {31'd0, busy}, 32'd1);
        check("b2b_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        wait_tx_idle();
        check("b2b_start_gap", start_cyc.size() == 2 ? start_cyc[1] - start_cyc[0] : -1, 10 * m_div);

        // READ on an empty FIFO stalls until a byte arrives
        send(I_READ, 8'h07, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_00A3);
        repeat (4) @(negedge clk);
        check("read_stall_busy", {31'd0, busy}, 32'd1);
        rx_frame(8'hA3, 1'b1);
        void'(m_fifo.pop_front());
        check("read_stall_done", exp_q.size(), 0);
        check("read_stall_released", {31'd0, cmd_ready}, 32'd1);

        // Nine bytes into an eight-deep FIFO
        for (int i = 0; i < 9; i++) rx_frame(8'h10 + 8'(i), 1'b1);
        tell(8'h00, m_fifo.size());
        tell(8'h02, m_ovr);
        tell(8'h02, 32'd1);
        tell(8'h01, {29'd0, 1'b0, m_fifo.size() == 8, m_fifo.size() == 0});
        tell(8'h09, 32'd0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = m_fifo.pop_front();
            send(I_READ, 8'h20 + 8'(i), 32'h0, 1'b0, 1'b1, 1'b1, {24'd0, b});
        end
        tell(8'h01, {29'd0, 1'b0, m_fifo.size() == 8, m_fifo.size() == 0});

        // Framing error, then a short glitch
        rx_frame(8'h5A, 1'b0);
        tell(8'h03, m_frm);
        tell(8'h03, 32'd1);
        tell(8'h00, m_fifo.size());
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        tell(8'h00, m_fifo.size());
        tell(8'h03, m_frm);

        // BAUDSET while a frame is in flight waits for the stop bit
        write_byte(8'h0F);
        send(I_BAUD, 8'h00, 32'd6, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("baud_wait_busy", {31'd0, busy}, 32'd1);
        wait_tx_idle();
        m_div = clamp_div(32'd6);
        send(I_DBG1, 8'h14, 32'h0, 1'b0, 1'b1, 1'b1, m_div);
        write_byte(8'h81);
        wait_tx_idle();

        // Commands for the other channel are ignored
        start_cyc.delete();
        send(I_TELL, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("other_ch_busy", {31'd0, busy}, 32'd0);
        check("other_ch_ready", {31'd0, cmd_ready}, 32'd1);
        send(I_WRITE, 8'h00, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (20) @(negedge clk);
        check("other_ch_no_frame", start_cyc.size(), 0);

        send(I_DBG2, 8'h15, 32'h0, 1'b0, 1'b1, 1'b1, {16'(m_txc), 16'(m_rxc)});
        send(I_DBG2, 8'h16, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0005_000A);
        send(I_BAUD, 8'h00, 32'h0001_2345, 1'b0, 1'b0, 1'b0, 32'h0);
        m_div = clamp_div(32'h0001_2345);
        send(I_DBG1, 8'h17, 32'h0, 1'b0, 1'b1, 1'b1, m_div);
        repeat (5) @(negedge clk);
        check("results_outstanding", exp_q.size(), 0);
        check("tx_frames_outstanding", tx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
